aes_block_loader: RTL and testbench
===================================

// Module: aes_block_loader
// PURPOSE
//  Upstream feeder for the iterative AES-128 encryption core. Collects a byte stream
//  (password/record data) into 128-bit blocks, pads the final partial block, launches
//  the core once per block, waits for completion, returns each cipher block on a
//  valid/ready output. One block in flight; the core is reused serially.
// PARAMETERS
//  AES_LATENCY  11  cycles from core_reset release to a valid core_cipher (timeout fallback)
//  CNT_W        4   width of the byte/latency counters (must cover 15 and AES_LATENCY)
// PORTS
//  clk             in   1    single clock, rising edge
//  reset_n         in   1    asynchronous, active-low reset
//  key             in   128  cipher key; sampled into core_key at block launch
//  in_data         in   8    input byte
//  in_valid        in   1    in_data valid
//  in_last         in   1    in_data is the final byte of the message
//  in_ready        out  1    loader accepts a byte this cycle
//  core_plaintext  out  128  block to the core, registered
//  core_key        out  128  key to the core, registered
//  core_reset      out  1    active-high synchronous restart to the core
//  core_cipher     in   128  core result
//  core_ready      in   1    core completion flag (may never assert; see WAIT)
//  out_block       out  128  cipher block
//  out_valid       out  1    out_block valid
//  out_last        out  1    out_block is the final block of the message
//  out_ready       in   1    downstream accepts out_block
// BEHAVIOUR
//  Reset (async, reset_n=0): state=COLLECT, byte_cnt=0, in_ready=0 for the first cycle
//   after release then 1; out_valid=0, out_last=0, core_reset=1, out_block/core_*=0.
//  States: COLLECT -> LAUNCH -> WAIT -> OUTPUT -> COLLECT.
//  COLLECT: in_ready=1. Byte accepted when in_valid&in_ready. Byte k (0..15) of the
//   block lands at bits [127-8k -: 8] (first byte = MSB). byte_cnt increments.
//   Go to LAUNCH when the 16th byte is accepted, or in_last is accepted.
//   On in_last with n bytes (1..15) accepted, bytes n..15 are filled with 8'(16-n).
//   A full 16-byte last block is sent unpadded. in_last on a zero-length message is
//   impossible (in_last always accompanies a byte). last flag latched for out_last.
//  LAUNCH (1 cycle): in_ready=0; core_plaintext/core_key loaded; core_reset=1.
//  WAIT: core_reset=0; lat_cnt counts from 0. Completes when core_ready=1 OR
//   lat_cnt==AES_LATENCY-1, whichever first; core_cipher captured into out_block.
//  OUTPUT: out_valid=1, out_block/out_last held stable until out_valid&out_ready;
//   then out_valid=0, byte_cnt=0, last flag cleared, back to COLLECT (core_reset=1).
//  Latency: last byte accepted -> out_valid = 1 (LAUNCH) + <=AES_LATENCY (WAIT) + 1.
//  in_ready=0 in LAUNCH/WAIT/OUTPUT: no input overlap; upstream stalls.
//  core_reset held 1 in COLLECT and LAUNCH so the core never free-runs on stale data.
//  key changes are ignored except at LAUNCH.
//  Async reset mid-block: partial block discarded, no out_valid, counters cleared.
// STRUCTURE
//  Shared package aes_pkg: BLOCK_W=128, BYTE_W=8, BYTES_PER_BLOCK=16, state enum
//   {ST_COLLECT, ST_LAUNCH, ST_WAIT, ST_OUTPUT}, default AES_LATENCY.
//  One sub-module: aes_pad_unit (combinational: partial block + byte count -> padded
//   block). Top instantiates aes_block_loader and the existing AES core side by side.
// TESTING
//  1. FIPS-197 vector: 16 bytes 00112233..eeff, key 000102..0f, in_last on byte 16 ->
//     out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1, no padding.
//  2. 5-byte message 61..65 with in_last -> core_plaintext=6162636465 followed by 11
//     bytes 0x0b; out_last=1.
//  3. 20-byte message -> two out blocks; first out_last=0, second holds 4 data bytes
//     + 12 bytes 0x0c, out_last=1.
//  4. out_ready held 0 for 10 cycles -> out_block stable, in_ready stays 0, no data
//     loss; release -> accepted in one cycle, in_ready=1 next cycle.
//  5. core_ready tied 0 -> completion exactly at AES_LATENCY timeout; core_ready
//     pulsed early in a second run -> completion on that cycle.
//  6. reset_n low during WAIT -> out_valid never asserts; next message of 1 byte
//     0x41 -> plaintext 41 + fifteen 0x0f.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES block loader.
//  - block/byte geometry of an AES-128 block
//  - loader state encoding
//  - default core latency used as the completion timeout
//  - pad_byte(): value used to fill the unused tail of a final partial block
package aes_pkg;

  localparam int BLOCK_W         = 128;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int AES_LATENCY_DEF = 11;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  // Pad value for a block holding n data bytes: each filler byte equals 16-n.
  function automatic logic [7:0] pad_byte(input logic [4:0] n);
    return 8'(5'd16 - n);
  endfunction

endpackage

// File: rtl/aes_block_loader_if.sv
// Byte-stream input and block-stream output of the AES block loader.
//  in_data/in_valid/in_last/in_ready  : byte stream into the loader
//  out_block/out_valid/out_last/out_ready : cipher block stream out of the loader
//  slave  modport : the loader side
//  master modport : the producer/consumer side
interface aes_block_loader_if;
  import aes_pkg::*;

  logic [BYTE_W-1:0]  in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [BLOCK_W-1:0] out_block;
  logic               out_valid;
  logic               out_last;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_block, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_block, out_valid, out_last
  );

endinterface

// File: rtl/aes_pad_unit.sv
// Combinational padder for the final block of a message.
//  blk_i      : block with data bytes in the top fill_cnt_i byte lanes (byte 0 = MSB)
//  fill_cnt_i : number of valid data bytes, 1..16
//  padded_o   : blk_i with lanes fill_cnt_i..15 replaced by 8'(16-fill_cnt_i);
//               a full block (fill_cnt_i = 16) passes through unchanged
module aes_pad_unit
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] blk_i,
  input  logic [4:0]         fill_cnt_i,
  output logic [BLOCK_W-1:0] padded_o
);

  logic [BYTE_W-1:0] pad_val;

  // Replace every byte lane at or beyond the data count with the pad value.
  always_comb begin
    padded_o = blk_i;
    pad_val  = pad_byte(fill_cnt_i);
    for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
      if (5'(k) >= fill_cnt_i) begin
        padded_o[BLOCK_W-1-BYTE_W*k -: BYTE_W] = pad_val;
      end else begin
        padded_o[BLOCK_W-1-BYTE_W*k -: BYTE_W] = blk_i[BLOCK_W-1-BYTE_W*k -: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Feeder for an iterative AES-128 core.
// Packs an incoming byte stream into 128-bit blocks (first byte = MSB), pads the
// final partial block, launches the core once per block, waits for core_ready or
// a fixed latency timeout, and presents each cipher block on a valid/ready output.
// Only one block is in flight; input is stalled from launch until the output
// block has been accepted.
//  clk, reset_n    : clock, asynchronous active-low reset
//  key             : cipher key, sampled only in the launch cycle
//  bus (slave)     : byte input stream and cipher block output stream
//  core_plaintext  : registered block to the core
//  core_key        : registered key to the core
//  core_reset      : active-high restart to the core, held in COLLECT/LAUNCH
//  core_cipher     : core result
//  core_ready      : core completion flag (may never assert)
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int AES_LATENCY = AES_LATENCY_DEF,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BLOCK_W-1:0] key,
  aes_block_loader_if.slave  bus,
  output logic [BLOCK_W-1:0] core_plaintext,
  output logic [BLOCK_W-1:0] core_key,
  output logic               core_reset,
  input  logic [BLOCK_W-1:0] core_cipher,
  input  logic               core_ready
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic               last_q, last_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [BLOCK_W-1:0] out_block_q, out_block_d;
  logic [BLOCK_W-1:0] core_plaintext_q, core_plaintext_d;
  logic [BLOCK_W-1:0] core_key_q, core_key_d;
  logic               core_reset_q, core_reset_d;

  logic               accept;
  logic               lat_done;
  logic [4:0]         fill_cnt;
  logic [BLOCK_W-1:0] blk_ins;
  logic [BLOCK_W-1:0] blk_padded;

  // in_ready_q is only ever set while the next state is COLLECT.
  assign accept   = bus.in_valid & in_ready_q & (state_q == ST_COLLECT);
  // Number of data bytes in the block once the current byte is included.
  assign fill_cnt = 5'(byte_cnt_q) + 5'd1;
  assign lat_done = core_ready | (lat_cnt_q == CNT_W'(AES_LATENCY - 1));

  // Block with the incoming byte written into lane byte_cnt_q.
  always_comb begin
    blk_ins = blk_q;
    for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
      if (CNT_W'(k) == byte_cnt_q) begin
        blk_ins[BLOCK_W-1-BYTE_W*k -: BYTE_W] = bus.in_data;
      end else begin
        blk_ins[BLOCK_W-1-BYTE_W*k -: BYTE_W] = blk_q[BLOCK_W-1-BYTE_W*k -: BYTE_W];
      end
    end
  end

  aes_pad_unit u_pad (
    .blk_i      (blk_ins),
    .fill_cnt_i (fill_cnt),
    .padded_o   (blk_padded)
  );

  // Next-state and datapath control for the collect/launch/wait/output sequence.
  always_comb begin
    state_d          = state_q;
    byte_cnt_d       = byte_cnt_q;
    lat_cnt_d        = lat_cnt_q;
    last_d           = last_q;
    blk_d            = blk_q;
    out_valid_d      = out_valid_q;
    out_last_d       = out_last_q;
    out_block_d      = out_block_q;
    core_plaintext_d = core_plaintext_q;
    core_key_d       = core_key_q;

    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          // Padding is applied as the final byte arrives, so the block
          // register is launch-ready and the counter may simply wrap.
          blk_d      = bus.in_last ? blk_padded : blk_ins;
          byte_cnt_d = byte_cnt_q + CNT_W'(1'b1);
          last_d     = bus.in_last;
          if (bus.in_last || (byte_cnt_q == CNT_W'(BYTES_PER_BLOCK - 1))) begin
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_LAUNCH: begin
        core_plaintext_d = blk_q;
        core_key_d       = key;
        lat_cnt_d        = '0;
        state_d          = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_done) begin
          out_block_d = core_cipher;
          out_valid_d = 1'b1;
          out_last_d  = last_q;
          state_d     = ST_OUTPUT;
        end else begin
          lat_cnt_d = lat_cnt_q + CNT_W'(1'b1);
        end
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          byte_cnt_d  = '0;
          last_d      = 1'b0;
          state_d     = ST_COLLECT;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase

    // Registered handshake/control outputs follow the state being entered.
    in_ready_d   = (state_d == ST_COLLECT);
    core_reset_d = (state_d == ST_COLLECT) || (state_d == ST_LAUNCH);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_COLLECT;
      byte_cnt_q       <= '0;
      lat_cnt_q        <= '0;
      last_q           <= 1'b0;
      blk_q            <= '0;
      in_ready_q       <= 1'b0;
      out_valid_q      <= 1'b0;
      out_last_q       <= 1'b0;
      out_block_q      <= '0;
      core_plaintext_q <= '0;
      core_key_q       <= '0;
      core_reset_q     <= 1'b1;
    end else begin
      state_q          <= state_d;
      byte_cnt_q       <= byte_cnt_d;
      lat_cnt_q        <= lat_cnt_d;
      last_q           <= last_d;
      blk_q            <= blk_d;
      in_ready_q       <= in_ready_d;
      out_valid_q      <= out_valid_d;
      out_last_q       <= out_last_d;
      out_block_q      <= out_block_d;
      core_plaintext_q <= core_plaintext_d;
      core_key_q       <= core_key_d;
      core_reset_q     <= core_reset_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_block  = out_block_q;
  assign core_plaintext = core_plaintext_q;
  assign core_key       = core_key_q;
  assign core_reset     = core_reset_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader with a stand-in AES core.
module tb_aes_block_loader;

  localparam int LAT = 11;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] key;
  logic [127:0] core_plaintext;
  logic [127:0] core_key;
  logic         core_reset;
  logic [127:0] core_cipher;
  logic         core_ready;

  int checks = 0;
  int errors = 0;
  int ready_delay = 3;
  int wait_cyc = 0;
  logic [7:0] msg[$];

  aes_block_loader_if bus ();

  aes_block_loader #(.AES_LATENCY(LAT), .CNT_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key            (key),
    .bus            (bus),
    .core_plaintext (core_plaintext),
    .core_key       (core_key),
    .core_reset     (core_reset),
    .core_cipher    (core_cipher),
    .core_ready     (core_ready)
  );

  always #5 clk = ~clk;

  // Stand-in core: FIPS-197 answer for the reference vector, a keyed scramble otherwise.
  function automatic logic [127:0] mock_aes(input logic [127:0] p, input logic [127:0] k);
    if (p == 128'h00112233445566778899aabbccddeeff && k == 128'h000102030405060708090a0b0c0d0e0f)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    else
      return {p[63:0], p[127:64]} ^ k ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_1234_5678;
  endfunction

  always @(posedge clk) begin
    if (core_reset) wait_cyc <= 0;
    else            wait_cyc <= wait_cyc + 1;
  end
  assign core_cipher = core_reset ? 128'h0 : mock_aes(core_plaintext, core_key);
  assign core_ready  = !core_reset && (ready_delay >= 0) && (wait_cyc == ready_delay);

  // Expected block b of msg: data bytes first (MSB first), tail filled with 16-n.
  function automatic logic [127:0] model_block(input int b);
    int n;
    logic [127:0] r;
    logic [7:0] v;
    n = msg.size() - b * 16;
    if (n > 16) n = 16;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      v = (k < n) ? msg[b * 16 + k] : 8'(16 - n);
      r = {r[119:0], v};
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Presents one byte (caller at a negedge) and returns at the negedge after acceptance.
  task automatic drive_byte(input logic [7:0] d, input logic last);
    int tmo;
    repeat ($urandom_range(0, 2)) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tmo = 0;
    while (!bus.in_ready && tmo < 40) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 40) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got in_ready=%0b exp 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Sends msg block by block and checks every resulting output block.
  task automatic run_message(input logic [127:0] k, input int stall);
    int nblk, n, t, waitc, exp_wait;
    logic [127:0] exp_pt, exp_ct, held;
    logic exp_last;
    nblk = (msg.size() + 15) / 16;
    for (int b = 0; b < nblk; b++) begin
      key = k;
      n = msg.size() - b * 16;
      if (n > 16) n = 16;
      exp_pt   = model_block(b);
      exp_ct   = mock_aes(exp_pt, k);
      exp_last = (b == nblk - 1);
      exp_wait = (ready_delay < 0 || ready_delay > LAT - 1) ? LAT : ready_delay + 1;
      for (int j = 0; j < n; j++) drive_byte(msg[b * 16 + j], (b * 16 + j) == (msg.size() - 1));
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL launch_in_ready got %0b exp 0", bus.in_ready);
      end
      waitc = 0; t = 0;
      do begin
        @(negedge clk);
        t++;
        if (t == 1) key = rnd128();  // key changes after launch must be ignored
        if (!bus.out_valid && !core_reset) waitc++;
      end while (!bus.out_valid && t < 60);
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL out_valid_timeout got %0b exp 1", bus.out_valid);
      end
      checks++;
      if (waitc != exp_wait) begin
        errors++; $display("FAIL wait_cycles got %0d exp %0d", waitc, exp_wait);
      end
      checks++;
      if (core_plaintext !== exp_pt) begin
        errors++; $display("FAIL plaintext got %h exp %h", core_plaintext, exp_pt);
      end
      checks++;
      if (core_key !== k) begin
        errors++; $display("FAIL core_key got %h exp %h", core_key, k);
      end
      checks++;
      if (bus.out_block !== exp_ct) begin
        errors++; $display("FAIL out_block got %h exp %h", bus.out_block, exp_ct);
      end
      checks++;
      if (bus.out_last !== exp_last) begin
        errors++; $display("FAIL out_last got %0b exp %0b", bus.out_last, exp_last);
      end
      held = bus.out_block;
      bus.out_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_block !== held || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold got v=%0b rdy=%0b blk=%h exp v=1 rdy=0 blk=%h",
                   bus.out_valid, bus.in_ready, bus.out_block, held);
        end
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL handshake got v=%0b rdy=%0b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        core_reset !== 1'b1 || bus.out_block !== 128'h0 || core_plaintext !== 128'h0 ||
        core_key !== 128'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b v=%0b l=%0b cr=%0b blk=%h pt=%h exp 0 0 0 1 0 0",
               bus.in_ready, bus.out_valid, bus.out_last, core_reset, bus.out_block, core_plaintext);
    end
    reset_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL release_in_ready0 got %0b exp 0", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || core_reset !== 1'b1) begin
      errors++; $display("FAIL release_in_ready1 got rdy=%0b cr=%0b exp 1 1", bus.in_ready, core_reset);
    end
  endtask

  task automatic test_fips();
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(8'(i * 17));
    ready_delay = 3;
    run_message(128'h000102030405060708090a0b0c0d0e0f, 1);
  endtask

  task automatic test_pad5();
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'(8'h61 + i));
    ready_delay = 5;
    run_message(rnd128(), 2);
  endtask

  task automatic test_two_blocks();
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom_range(0, 255)));
    ready_delay = 2;
    run_message(rnd128(), 0);
  endtask

  task automatic test_backpressure();
    msg.delete();
    for (int i = 0; i < 9; i++) msg.push_back(8'($urandom_range(0, 255)));
    ready_delay = 1;
    run_message(rnd128(), 10);
  endtask

  task automatic test_timeout();
    msg.delete();
    for (int i = 0; i < 7; i++) msg.push_back(8'($urandom_range(0, 255)));
    ready_delay = -1;
    run_message(rnd128(), 0);
    ready_delay = 0;
    run_message(rnd128(), 0);
    ready_delay = 6;
    run_message(rnd128(), 0);
  endtask

  task automatic test_reset_wait();
    int t;
    ready_delay = -1;
    key = rnd128();
    drive_byte(8'h11, 1'b0);
    drive_byte(8'h22, 1'b0);
    drive_byte(8'h33, 1'b1);
    t = 0;
    while (core_reset && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || core_reset !== 1'b1 || bus.in_ready !== 1'b0 || core_plaintext !== 128'h0) begin
      errors++;
      $display("FAIL reset_in_wait got v=%0b cr=%0b rdy=%0b pt=%h exp 0 1 0 0",
               bus.out_valid, core_reset, bus.in_ready, core_plaintext);
    end
    @(negedge clk);
    reset_n = 1'b1;
    t = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) t++;
    end
    checks++;
    if (t != 0) begin
      errors++; $display("FAIL no_out_after_reset got %0d valid cycles exp 0", t);
    end
    msg.delete();
    msg.push_back(8'h41);
    ready_delay = 4;
    run_message(rnd128(), 1);
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      msg.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) msg.push_back(8'($urandom_range(0, 255)));
      ready_delay = int'($urandom_range(0, 13)) - 1;
      run_message(rnd128(), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    key           = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fips();
    test_pad5();
    test_two_blocks();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
